// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK up/down counter: JK drive encodings and default geometry.
package jk_updown_counter_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

endpackage

// File: rtl/jk_updown_counter_ff.sv
// Single JK flip-flop stage with synchronous active-high clear; q_bar is always the complement of q.
module JK_FF
  import jk_updown_counter_pkg::*;
(
  output logic q,
  output logic q_bar,
  input  logic clear,
  input  logic clk,
  input  logic j,
  input  logic k
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_SET:    q <= 1'b1;
        JK_RESET:  q <= 1'b0;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_updown_counter_next.sv
// Combinational next-count and J/K drive for the mod-MODULUS counter; only hold or toggle is ever driven.
module jk_next_state
  import jk_updown_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc
);

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic at_max;
  logic at_zero;
  logic out_of_range;

  assign at_max       = (count == MAX_VAL);
  assign at_zero      = (count == '0);
  assign out_of_range = ({1'b0, count} >= MOD_EXT);

  always_comb begin
    next = count;
    if (load) begin
      next = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end else if (en) begin
      if (out_of_range) begin
        next = '0;
      end else if (up) begin
        next = at_max ? '0 : count + WIDTH'(1);
      end else begin
        next = at_zero ? MAX_VAL : count - WIDTH'(1);
      end
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = (next[i] != count[i]) ? JK_TOGGLE : JK_HOLD;
    end
  end

  assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

endmodule

// File: rtl/jk_updown_counter.sv
// Mod-MODULUS up/down counter: one JK_FF per bit, driven by jk_next_state; the flops are the only state.
module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc
);

  logic [WIDTH-1:0] next;
  logic [WIDTH-1:0] j_drive;
  logic [WIDTH-1:0] k_drive;
  logic             tc_raw;

  jk_next_state #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .count   (count),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .next    (next),
    .j       (j_drive),
    .k       (k_drive),
    .tc      (tc_raw)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    JK_FF u_ff (
      .q    (count[i]),
      .q_bar(count_n[i]),
      .clear(clear),
      .clk  (clk),
      .j    (j_drive[i]),
      .k    (k_drive[i])
    );
  end

  assign tc = tc_raw & ~clear;

  // The JK stages must land exactly on the value the helper asked for.
  a_next_tracks: assert property (@(posedge clk) !clear |=> count == $past(next));

endmodule
